// File: rtl/osc_freq_seg_display.sv
// Counts rising edges of one selected oscillator over a fixed clk window and shows the count as a hex digit.
// Optional macro OVF_BLINK_EN: a saturated result (F) blinks on successive windows instead of holding steady.
module osc_freq_seg_display #(
  parameter int N_OSC       = 8,
  parameter int WIN_CYCLES  = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic [N_OSC-1:0]         osc_in,
  input  logic [$clog2(N_OSC)-1:0] sel,
  output logic [6:0]               seg_out,
  output logic                     done
);
  localparam int SEL_W = $clog2(N_OSC);
  localparam int WIN_W = $clog2(WIN_CYCLES);
  localparam int ARM_W = $clog2(SYNC_STAGES + 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYCLES - 1);
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(SYNC_STAGES);

  typedef enum logic [1:0] {IDLE, ARM, COUNT} state_t;

  state_t             state_q, state_d;
  logic [ARM_W-1:0]   arm_q, arm_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [6:0]         seg_q, seg_d;
  logic               done_q, done_d;
  logic [SEL_W-1:0]   sel_q;
  logic [N_OSC-1:0]   sync_q [SYNC_STAGES];
  logic [N_OSC-1:0]   prev_q;
  logic [SEL_W-1:0]   sel_idx;
  logic               osc_rise;
  logic               sel_chg;
  logic [4:0]         sum;
  logic [3:0]         result;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h3F; 4'h1: hex7 = 7'h06; 4'h2: hex7 = 7'h5B; 4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66; 4'h5: hex7 = 7'h6D; 4'h6: hex7 = 7'h7D; 4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F; 4'h9: hex7 = 7'h6F; 4'hA: hex7 = 7'h77; 4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39; 4'hD: hex7 = 7'h5E; 4'hE: hex7 = 7'h79; default: hex7 = 7'h71;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
      sel_q  <= '0;
    end else begin
      sync_q[0] <= osc_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
      sel_q  <= sel;
    end
  end

  // Out-of-range selects fall back to channel 0.
  always_comb begin
    sel_idx  = (32'(sel) < N_OSC) ? sel : '0;
    osc_rise = sync_q[SYNC_STAGES-1][sel_idx] & ~prev_q[sel_idx];
    sel_chg  = (sel != sel_q);
    sum      = {1'b0, cnt_q} + 5'(osc_rise);
    result   = sum[4] ? 4'hF : sum[3:0];
  end

`ifdef OVF_BLINK_EN
  logic blink_q, blink_d;
  always_ff @(posedge clk) begin
    if (!rst_n) blink_q <= 1'b0;
    else        blink_q <= blink_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    arm_d   = arm_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    seg_d   = seg_q;
    done_d  = 1'b0;
`ifdef OVF_BLINK_EN
    blink_d = blink_q;
`endif
    // Disable beats a simultaneous select change.
    if (!ena) begin
      state_d = IDLE;
      arm_d   = '0;
      win_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ARM;
          arm_d   = '0;
          win_d   = '0;
          cnt_d   = '0;
        end
        ARM: begin
          if (sel_chg) begin
            arm_d = '0;
          end else if (arm_q == ARM_LAST) begin
            state_d = COUNT;
            win_d   = '0;
            cnt_d   = '0;
          end else begin
            arm_d = arm_q + 1'b1;
          end
        end
        COUNT: begin
          if (sel_chg) begin
            state_d = ARM;
            arm_d   = '0;
            win_d   = '0;
            cnt_d   = '0;
          end else if (win_q == WIN_LAST) begin
            done_d = 1'b1;
            win_d  = '0;
            cnt_d  = '0;
`ifdef OVF_BLINK_EN
            if (result == 4'hF) begin
              seg_d   = blink_q ? 7'h00 : 7'h71;
              blink_d = ~blink_q;
            end else begin
              seg_d   = hex7(result);
              blink_d = 1'b0;
            end
`else
            seg_d = hex7(result);
`endif
          end else begin
            win_d = win_q + 1'b1;
            cnt_d = result;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      arm_q   <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      seg_q   <= 7'h3F;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      arm_q   <= arm_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      seg_q   <= seg_d;
      done_q  <= done_d;
    end
  end

  assign seg_out = seg_q;
  assign done    = done_q;
endmodule
